plane_job_queue: RTL and testbench

//  Downstream of the job decoder. Buffers decoded jobs {host_id, plane_id, meta_data} in one FIFO per plane.

---
 rtl/plane_job_queue.sv | 168 ++++++++++++++++
 tb/tb_plane_job_queue.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plane_job_queue.sv
// plane_job_queue: one FIFO per NAND plane, round-robin issue through a registered valid/ready port.
// Optional macro PLANE_JOB_QUEUE_STATS_EN adds o_drop_cnt and o_occupancy.
`ifndef MAX_HOST_NUMBER
`define MAX_HOST_NUMBER 4
`endif
`ifndef MAX_PLANE_NUMBER
`define MAX_PLANE_NUMBER 4
`endif
`ifndef NO_OF_TAG
`define NO_OF_TAG 64
`endif

module plane_job_queue #(
    parameter int unsigned MAX_HOST_NUMBER     = `MAX_HOST_NUMBER,
    parameter int unsigned MAX_PLANE_NUMBER    = `MAX_PLANE_NUMBER,
    parameter int unsigned NO_OF_TAG           = `NO_OF_TAG,
    parameter int unsigned QUEUE_DEPTH         = 4,
    localparam int unsigned HOST_ID_BIT_WIDTH   = $clog2(MAX_HOST_NUMBER),
    localparam int unsigned PLANE_ID_BIT_WIDTH  = $clog2(MAX_PLANE_NUMBER),
    localparam int unsigned META_DATA_BIT_WIDTH = 128 - $clog2(NO_OF_TAG) - HOST_ID_BIT_WIDTH - 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_job_valid,
    input  logic [HOST_ID_BIT_WIDTH-1:0]   i_host_id,
    input  logic [PLANE_ID_BIT_WIDTH-1:0]  i_plane_id,
    input  logic [META_DATA_BIT_WIDTH-1:0] i_meta_data,
    output logic [MAX_PLANE_NUMBER-1:0]    o_plane_full,
    output logic                           o_overflow,
    output logic                           o_job_valid,
    input  logic                           i_job_ready,
    output logic [HOST_ID_BIT_WIDTH-1:0]   o_job_host_id,
    output logic [PLANE_ID_BIT_WIDTH-1:0]  o_job_plane_id,
`ifdef PLANE_JOB_QUEUE_STATS_EN
    output logic [15:0]                    o_drop_cnt,
    output logic [15:0]                    o_occupancy,
`endif
    output logic [META_DATA_BIT_WIDTH-1:0] o_job_meta_data
);

    localparam int unsigned PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = HOST_ID_BIT_WIDTH + META_DATA_BIT_WIDTH;

    logic [ENTRY_W-1:0]            r_mem    [MAX_PLANE_NUMBER][QUEUE_DEPTH];
    logic [PTR_W-1:0]              r_wr_ptr [MAX_PLANE_NUMBER];
    logic [PTR_W-1:0]              r_rd_ptr [MAX_PLANE_NUMBER];
    logic [CNT_W-1:0]              r_count  [MAX_PLANE_NUMBER];
    logic [PLANE_ID_BIT_WIDTH-1:0] r_rr_ptr;

    logic [MAX_PLANE_NUMBER-1:0]   w_full;
    logic [MAX_PLANE_NUMBER-1:0]   w_push_vec;
    logic [MAX_PLANE_NUMBER-1:0]   w_pop_vec;
    logic                          w_push;
    logic                          w_drop;
    logic                          w_load;
    logic                          w_gnt_valid;
    logic [PLANE_ID_BIT_WIDTH-1:0] w_gnt_idx;
    logic [PLANE_ID_BIT_WIDTH-1:0] w_cand;
    logic [ENTRY_W-1:0]            w_head;

    assign o_plane_full = w_full;

    // Full check uses pre-edge count, so a same-edge pop never rescues an incoming job.
    assign w_push = i_job_valid && !w_full[i_plane_id];
    assign w_drop = i_job_valid &&  w_full[i_plane_id];
    assign w_load = !o_job_valid || i_job_ready;
    assign w_head = r_mem[w_gnt_idx][r_rd_ptr[w_gnt_idx]];

    // Round-robin search upward from r_rr_ptr over planes with a non-zero count.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = '0;
        for (int unsigned k = 0; k < MAX_PLANE_NUMBER; k++) begin
            w_cand = PLANE_ID_BIT_WIDTH'((32'(r_rr_ptr) + k) % MAX_PLANE_NUMBER);
            if (!w_gnt_valid && (r_count[w_cand] != '0)) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = w_cand;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < MAX_PLANE_NUMBER; g++) begin : g_plane
            assign w_full[g]     = (r_count[g] == CNT_W'(QUEUE_DEPTH));
            assign w_push_vec[g] = w_push && (i_plane_id == PLANE_ID_BIT_WIDTH'(g));
            assign w_pop_vec[g]  = w_load && w_gnt_valid && (w_gnt_idx == PLANE_ID_BIT_WIDTH'(g));

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_wr_ptr[g] <= '0;
                    r_rd_ptr[g] <= '0;
                    r_count[g]  <= '0;
                end else begin
                    if (w_push_vec[g]) begin
                        r_wr_ptr[g] <= r_wr_ptr[g] + PTR_W'(1);
                    end
                    if (w_pop_vec[g]) begin
                        r_rd_ptr[g] <= r_rd_ptr[g] + PTR_W'(1);
                    end
                    case ({w_push_vec[g], w_pop_vec[g]})
                        2'b10:   r_count[g] <= r_count[g] + CNT_W'(1);
                        2'b01:   r_count[g] <= r_count[g] - CNT_W'(1);
                        default: r_count[g] <= r_count[g];
                    endcase
                end
            end
        end
    endgenerate

    // Queue storage carries no reset; emptiness lives in the pointers and counts.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[i_plane_id][r_wr_ptr[i_plane_id]] <= {i_host_id, i_meta_data};
        end
    end

    // Output register, overflow pulse and round-robin pointer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_job_valid     <= 1'b0;
            o_job_host_id   <= '0;
            o_job_plane_id  <= '0;
            o_job_meta_data <= '0;
            o_overflow      <= 1'b0;
            r_rr_ptr        <= '0;
        end else begin
            o_overflow <= w_drop;
            if (w_load) begin
                if (w_gnt_valid) begin
                    o_job_valid     <= 1'b1;
                    o_job_host_id   <= w_head[ENTRY_W-1 -: HOST_ID_BIT_WIDTH];
                    o_job_plane_id  <= w_gnt_idx;
                    o_job_meta_data <= w_head[META_DATA_BIT_WIDTH-1:0];
                    r_rr_ptr        <= PLANE_ID_BIT_WIDTH'((32'(w_gnt_idx) + 32'd1) % MAX_PLANE_NUMBER);
                end else begin
                    o_job_valid <= 1'b0;
                end
            end
        end
    end

`ifdef PLANE_JOB_QUEUE_STATS_EN
    logic [15:0] r_drop_cnt;
    logic [15:0] w_occupancy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    always_comb begin
        w_occupancy = '0;
        for (int unsigned p = 0; p < MAX_PLANE_NUMBER; p++) begin
            w_occupancy = w_occupancy + 16'(r_count[PLANE_ID_BIT_WIDTH'(p)]);
        end
    end

    assign o_drop_cnt  = r_drop_cnt;
    assign o_occupancy = w_occupancy;
`endif

endmodule

// File: tb/tb_plane_job_queue.sv
// Bench for plane_job_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_plane_job_queue;

    localparam int unsigned NP = 4;
    localparam int unsigned QD = 4;
    localparam int unsigned HW = 2;
    localparam int unsigned PW = 2;
    localparam int unsigned MW = 128 - 6 - HW - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_job_valid;
    logic [HW-1:0] i_host_id;
    logic [PW-1:0] i_plane_id;
    logic [MW-1:0] i_meta_data;
    logic [NP-1:0] o_plane_full;
    logic          o_overflow;
    logic          o_job_valid;
    logic          i_job_ready;
    logic [HW-1:0] o_job_host_id;
    logic [PW-1:0] o_job_plane_id;
    logic [MW-1:0] o_job_meta_data;
`ifdef PLANE_JOB_QUEUE_STATS_EN
    logic [15:0]   o_drop_cnt;
    logic [15:0]   o_occupancy;
`endif

    plane_job_queue #(
        .MAX_HOST_NUMBER (4),
        .MAX_PLANE_NUMBER(NP),
        .NO_OF_TAG       (64),
        .QUEUE_DEPTH     (QD)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_job_valid    (i_job_valid),
        .i_host_id      (i_host_id),
        .i_plane_id     (i_plane_id),
        .i_meta_data    (i_meta_data),
        .o_plane_full   (o_plane_full),
        .o_overflow     (o_overflow),
        .o_job_valid    (o_job_valid),
        .i_job_ready    (i_job_ready),
        .o_job_host_id  (o_job_host_id),
        .o_job_plane_id (o_job_plane_id),
`ifdef PLANE_JOB_QUEUE_STATS_EN
        .o_drop_cnt     (o_drop_cnt),
        .o_occupancy    (o_occupancy),
`endif
        .o_job_meta_data(o_job_meta_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [HW-1:0] host;
        logic [MW-1:0] meta;
    } job_t;

    // Reference model: plain queues per plane plus the single output slot.
    job_t          mq [NP][$];
    bit            m_valid;
    logic [HW-1:0] m_host;
    logic [PW-1:0] m_plane;
    logic [MW-1:0] m_meta;
    bit            m_ovf;
    int            m_rr;
    int            m_drop;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void model_reset();
        for (int p = 0; p < NP; p++) mq[p].delete();
        m_valid = 0; m_host = '0; m_plane = '0; m_meta = '0;
        m_ovf = 0; m_rr = 0; m_drop = 0;
    endfunction

    function automatic logic [NP-1:0] model_full();
        logic [NP-1:0] f;
        for (int p = 0; p < NP; p++) f[p] = (mq[p].size() == QD);
        return f;
    endfunction

    function automatic int model_occ();
        int s = 0;
        for (int p = 0; p < NP; p++) s += mq[p].size();
        return s;
    endfunction

    function automatic logic [MW-1:0] rand_meta();
        return MW'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    // Drive one cycle, advance the model at the edge, return 1 time unit after the edge.
    task automatic cycle(input bit jv, input int plane, input logic [HW-1:0] host,
                         input logic [MW-1:0] meta, input bit ready);
        bit   load, drop, found;
        int   gi, idx;
        job_t j;
        i_job_valid = jv;
        i_plane_id  = PW'(plane);
        i_host_id   = host;
        i_meta_data = meta;
        i_job_ready = ready;
        @(posedge clk);
        load  = !m_valid || ready;
        drop  = jv && (mq[plane].size() == QD);
        found = 0;
        gi    = 0;
        if (load) begin
            for (int k = 0; k < NP; k++) begin
                idx = (m_rr + k) % NP;
                if (!found && mq[idx].size() > 0) begin
                    found = 1;
                    gi    = idx;
                end
            end
            if (found) begin
                j       = mq[gi].pop_front();
                m_valid = 1;
                m_host  = j.host;
                m_meta  = j.meta;
                m_plane = PW'(gi);
                m_rr    = (gi + 1) % NP;
            end else begin
                m_valid = 0;
            end
        end
        m_ovf = drop;
        if (drop && m_drop < 65535) m_drop++;
        if (jv && !drop) mq[plane].push_back({host, meta});
        #1;
        i_job_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (o_job_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %0b exp 0", o_job_valid); end
        n_checks++; if (o_overflow !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got %0b exp 0", o_overflow); end
        n_checks++; if (o_plane_full !== 4'b0000) begin n_errors++; $display("FAIL reset_full got %b exp 0000", o_plane_full); end
        n_checks++; if ({o_job_host_id, o_job_plane_id, o_job_meta_data} !== '0) begin n_errors++; $display("FAIL reset_data got %0h exp 0", o_job_meta_data); end
        rst = 1'b0;
        model_reset();
        // Fill: one job into the output slot, three left in queues.
        for (int p = 0; p < 4; p++) cycle(1, p, HW'(p), rand_meta(), 0);
        n_checks++; if (o_job_valid !== 1'b1) begin n_errors++; $display("FAIL prereset_valid got %0b exp 1", o_job_valid); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (o_job_valid !== 1'b0) begin n_errors++; $display("FAIL async_reset_valid got %0b exp 0", o_job_valid); end
        n_checks++; if ({o_job_host_id, o_job_plane_id, o_job_meta_data, o_overflow, o_plane_full} !== '0) begin
            n_errors++; $display("FAIL async_reset_outputs got %0h exp 0", {o_job_host_id, o_job_plane_id, o_job_meta_data, o_overflow, o_plane_full});
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, '0, '0, 1);
            n_checks++; if (o_job_valid !== 1'b0) begin n_errors++; $display("FAIL stale_after_reset cyc %0d got %0b exp 0", i, o_job_valid); end
        end
    endtask

    task automatic test_single_job();
        do_reset();
        cycle(1, 2, 2'd1, MW'(8'hA5), 1);
        n_checks++; if (o_job_valid !== 1'b0) begin n_errors++; $display("FAIL single_edgeN_valid got %0b exp 0", o_job_valid); end
        cycle(0, 0, '0, '0, 1);
        n_checks++; if (o_job_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid got %0b exp 1", o_job_valid); end
        n_checks++; if ({o_job_plane_id, o_job_host_id} !== {2'd2, 2'd1}) begin n_errors++; $display("FAIL single_ids got p%0d h%0d exp p2 h1", o_job_plane_id, o_job_host_id); end
        n_checks++; if (o_job_meta_data !== MW'(8'hA5)) begin n_errors++; $display("FAIL single_meta got %0h exp a5", o_job_meta_data); end
        cycle(0, 0, '0, '0, 1);
        n_checks++; if (o_job_valid !== 1'b0) begin n_errors++; $display("FAIL single_after_valid got %0b exp 0", o_job_valid); end
    endtask

    task automatic test_overflow();
        logic [MW-1:0] got;
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            cycle(1, 1, HW'(i), MW'(10 + i), 0);
            n_checks++; if (o_plane_full !== ((i >= 5) ? 4'b0010 : 4'b0000)) begin n_errors++; $display("FAIL ovf_full job %0d got %b exp %b", i, o_plane_full, (i >= 5) ? 4'b0010 : 4'b0000); end
            n_checks++; if (o_overflow !== (i == 6)) begin n_errors++; $display("FAIL ovf_pulse job %0d got %0b exp %0b", i, o_overflow, i == 6); end
            n_checks++; if (o_job_valid !== (i >= 2)) begin n_errors++; $display("FAIL ovf_valid job %0d got %0b exp %0b", i, o_job_valid, i >= 2); end
        end
        cycle(0, 0, '0, '0, 0);
        n_checks++; if (o_overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_one_shot got %0b exp 0", o_overflow); end
        for (int i = 1; i <= 5; i++) begin
            got = o_job_meta_data;
            n_checks++; if (!o_job_valid || got !== MW'(10 + i)) begin n_errors++; $display("FAIL ovf_drain %0d got v%0b %0d exp %0d", i, o_job_valid, got, 10 + i); end
            cycle(0, 0, '0, '0, 1);
        end
        n_checks++; if (o_job_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_drained got %0b exp 0", o_job_valid); end
    endtask

    task automatic test_round_robin();
        int exp_plane [4];
        int exp_meta  [4];
        exp_plane = '{0, 2, 0, 2};
        exp_meta  = '{1, 3, 2, 4};
        do_reset();
        cycle(1, 0, 2'd0, MW'(1), 0);
        cycle(1, 0, 2'd0, MW'(2), 0);
        cycle(1, 2, 2'd2, MW'(3), 0);
        cycle(1, 2, 2'd2, MW'(4), 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (!o_job_valid || o_job_plane_id !== PW'(exp_plane[i]) || o_job_meta_data !== MW'(exp_meta[i])) begin
                n_errors++; $display("FAIL rr_issue %0d got v%0b p%0d m%0d exp p%0d m%0d", i, o_job_valid, o_job_plane_id, o_job_meta_data, exp_plane[i], exp_meta[i]);
            end
            cycle(0, 0, '0, '0, 1);
        end
        n_checks++; if (o_job_valid !== 1'b0) begin n_errors++; $display("FAIL rr_empty got %0b exp 0", o_job_valid); end
    endtask

    task automatic test_stall();
        logic [HW+PW+MW-1:0] prev;
        bit  prev_valid, rdy;
        int  issued = 0;
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, $urandom_range(0, 3), HW'($urandom()), rand_meta(), 0);
        for (int i = 0; i < 14; i++) begin
            prev       = {o_job_host_id, o_job_plane_id, o_job_meta_data};
            prev_valid = o_job_valid;
            rdy        = (i % 2 == 1);
            cycle(0, 0, '0, '0, rdy);
            if (prev_valid && rdy) issued++;
            if (prev_valid && !rdy) begin
                n_checks++; if ({o_job_host_id, o_job_plane_id, o_job_meta_data} !== prev || !o_job_valid) begin
                    n_errors++; $display("FAIL stall_hold cyc %0d got %0h exp %0h", i, o_job_meta_data, prev[MW-1:0]);
                end
            end
            n_checks++; if (o_job_valid !== m_valid || (m_valid && o_job_meta_data !== m_meta)) begin
                n_errors++; $display("FAIL stall_model cyc %0d got v%0b %0h exp v%0b %0h", i, o_job_valid, o_job_meta_data, m_valid, m_meta);
            end
        end
        n_checks++; if (issued != 3) begin n_errors++; $display("FAIL stall_issued got %0d exp 3", issued); end
    endtask

    task automatic test_same_cycle_push_pop();
        int n_out = 0;
        bit saw99 = 0;
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 3, 2'd3, MW'(20 + i), 0);
        n_checks++; if (o_plane_full !== 4'b1000) begin n_errors++; $display("FAIL spp_full_before got %b exp 1000", o_plane_full); end
        cycle(1, 3, 2'd3, MW'(99), 1);
        n_checks++; if (o_overflow !== 1'b1) begin n_errors++; $display("FAIL spp_ovf got %0b exp 1", o_overflow); end
        n_checks++; if (o_plane_full !== 4'b0000) begin n_errors++; $display("FAIL spp_full_after got %b exp 0000", o_plane_full); end
        n_checks++; if (!o_job_valid || o_job_meta_data !== MW'(21)) begin n_errors++; $display("FAIL spp_next got v%0b %0d exp 21", o_job_valid, o_job_meta_data); end
`ifdef PLANE_JOB_QUEUE_STATS_EN
        n_checks++; if (o_occupancy !== 16'd3) begin n_errors++; $display("FAIL spp_occ got %0d exp 3", o_occupancy); end
`endif
        for (int i = 0; i < 8; i++) begin
            if (o_job_valid) begin
                n_out++;
                if (o_job_meta_data === MW'(99)) saw99 = 1;
            end
            cycle(0, 0, '0, '0, 1);
        end
        n_checks++; if (n_out != 4 || saw99) begin n_errors++; $display("FAIL spp_drain got %0d issued dropped_seen %0b exp 4 0", n_out, saw99); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom() % 3) != 0, $urandom_range(0, 3), HW'($urandom()), rand_meta(), ($urandom() % 2) == 0);
            n_checks++; if (o_job_valid !== m_valid) begin n_errors++; $display("FAIL rand_valid cyc %0d got %0b exp %0b", i, o_job_valid, m_valid); end
            if (m_valid) begin
                n_checks++; if ({o_job_host_id, o_job_plane_id, o_job_meta_data} !== {m_host, m_plane, m_meta}) begin
                    n_errors++; $display("FAIL rand_job cyc %0d got h%0d p%0d %0h exp h%0d p%0d %0h", i, o_job_host_id, o_job_plane_id, o_job_meta_data, m_host, m_plane, m_meta);
                end
            end
            n_checks++; if (o_overflow !== m_ovf) begin n_errors++; $display("FAIL rand_ovf cyc %0d got %0b exp %0b", i, o_overflow, m_ovf); end
            n_checks++; if (o_plane_full !== model_full()) begin n_errors++; $display("FAIL rand_full cyc %0d got %b exp %b", i, o_plane_full, model_full()); end
`ifdef PLANE_JOB_QUEUE_STATS_EN
            n_checks++; if (o_drop_cnt !== 16'(m_drop)) begin n_errors++; $display("FAIL rand_drop_cnt cyc %0d got %0d exp %0d", i, o_drop_cnt, m_drop); end
            n_checks++; if (o_occupancy !== 16'(model_occ())) begin n_errors++; $display("FAIL rand_occ cyc %0d got %0d exp %0d", i, o_occupancy, model_occ()); end
`endif
        end
    endtask

    initial begin
        rst         = 1'b1;
        i_job_valid = 1'b0;
        i_host_id   = '0;
        i_plane_id  = '0;
        i_meta_data = '0;
        i_job_ready = 1'b0;
        model_reset();
        test_reset();
        test_single_job();
        test_overflow();
        test_round_robin();
        test_stall();
        test_same_cycle_push_pop();
        do_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
